// File: rtl/add_sub4_reg.sv
// 4-bit signed adder/subtractor built from a full-adder ripple, with a registered
// 5-bit signed result and the raw (not sign-corrected) carry out of bit 3.
module add_sub4_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [4:0] sum,
  output logic       c_out
);

  logic [3:0] bx;
  logic [4:0] carry;
  logic [3:0] s;
  logic [4:0] sum_d, sum_q;
  logic       c_out_d, c_out_q;

  // Subtract is a + ~b + 1 - c_in, so both b and the carry-in are inverted by op.
  always_comb begin
    bx       = b ^ {4{op}};
    carry    = '0;
    carry[0] = c_in ^ op;
    s        = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]       = a[i] ^ bx[i] ^ carry[i];
      carry[i+1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
    end
    // Sign bit of sext(a) + sext(bx) + ci, which never overflows at 5 bits.
    sum_d   = {a[3] ^ bx[3] ^ carry[4], s};
    c_out_d = carry[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_add_sub4_reg.sv
// Directed table plus exhaustive sweep for add_sub4_reg, with 1-cycle latency and
// output-hold checks against an integer reference model.
module tb_add_sub4_reg;

  logic       clk;
  logic       rst;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [4:0] sum;
  logic       c_out;

  int total;
  int bad;

  logic [4:0] prev_sum;
  logic       prev_cout;
  bit         have_prev;

  typedef struct {
    logic       rst;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [4:0] sum;
    logic       c_out;
    string      name;
  } vec_t;

  vec_t vecs[12];

  add_sub4_reg dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] es, input logic ec);
    total++;
    if (sum !== es || c_out !== ec) begin
      bad++;
      $display("FAIL %s: got sum=%b c_out=%b, expected sum=%b c_out=%b",
               name, sum, c_out, es, ec);
    end
  endtask

  // Drive on the falling edge, confirm the output still holds the previous result,
  // then check the new result just after the capturing rising edge.
  task automatic step(input logic r, input logic o, input logic [3:0] av, input logic [3:0] bv,
                      input logic ci, input logic [4:0] es, input logic ec, input string name);
    @(negedge clk);
    rst  = r;
    op   = o;
    a    = av;
    b    = bv;
    c_in = ci;
    #1;
    if (have_prev) check({name, "_hold"}, prev_sum, prev_cout);
    @(posedge clk);
    #1;
    check(name, es, ec);
    prev_sum  = es;
    prev_cout = ec;
    have_prev = 1'b1;
  endtask

  task automatic model(input logic o, input logic [3:0] av, input logic [3:0] bv,
                       input logic ci, output logic [4:0] es, output logic ec);
    int sa, sb, res, ua, ub, ures;
    logic [31:0] rv;
    sa = av[3] ? int'(av) - 16 : int'(av);
    sb = bv[3] ? int'(bv) - 16 : int'(bv);
    ua = int'(av);
    ub = int'(bv);
    if (o) begin
      res  = sa - sb - int'(ci);
      ures = ua - ub - int'(ci);
      ec   = (ures >= 0);
    end else begin
      res  = sa + sb + int'(ci);
      ures = ua + ub + int'(ci);
      ec   = (ures >= 16);
    end
    rv = res;
    es = rv[4:0];
  endtask

  initial begin
    logic [4:0] es;
    logic       ec;
    total     = 0;
    bad       = 0;
    have_prev = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    rst  = 1'b1;
    op   = 1'b0;
    a    = '0;
    b    = '0;
    c_in = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 5'd0,      1'b0, "reset"};
    vecs[1]  = '{1'b0, 1'b0, 4'd5,  4'd0,  1'b0, 5'd5,      1'b0, "add_5_0"};
    vecs[2]  = '{1'b0, 1'b0, 4'd7,  4'd7,  1'b1, 5'd15,     1'b0, "add_max"};
    vecs[3]  = '{1'b0, 1'b0, 4'h8,  4'h8,  1'b0, 5'b10000,  1'b1, "add_min"};
    vecs[4]  = '{1'b0, 1'b1, 4'd5,  4'd3,  1'b0, 5'd2,      1'b1, "sub_5_3"};
    vecs[5]  = '{1'b0, 1'b1, 4'd3,  4'd5,  1'b0, 5'b11110,  1'b0, "sub_3_5"};
    vecs[6]  = '{1'b0, 1'b1, 4'h8,  4'd7,  1'b1, 5'b10000,  1'b1, "sub_min"};
    vecs[7]  = '{1'b0, 1'b1, 4'd7,  4'h8,  1'b0, 5'd15,     1'b0, "sub_max"};
    vecs[8]  = '{1'b0, 1'b0, 4'h8,  4'h8,  1'b1, 5'b10001,  1'b1, "add_m8m8c"};
    vecs[9]  = '{1'b1, 1'b0, 4'd7,  4'd7,  1'b1, 5'd0,      1'b0, "reset_mid"};
    vecs[10] = '{1'b0, 1'b0, 4'd1,  4'd2,  1'b0, 5'd3,      1'b0, "after_reset"};
    vecs[11] = '{1'b0, 1'b1, 4'd0,  4'd1,  1'b1, 5'b11110,  1'b0, "sub_0_1_b"};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c_in,
           vecs[i].sum, vecs[i].c_out, vecs[i].name);
    end

    // Reset held two cycles over live inputs, then immediate restart.
    step(1'b1, 1'b1, 4'd6, 4'h9, 1'b1, 5'd0, 1'b0, "reset_hold1");
    step(1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 5'd0, 1'b0, "reset_hold2");
    step(1'b0, 1'b1, 4'd6, 4'h9, 1'b1, 5'd12, 1'b0, "restart_sub");

    for (int o = 0; o < 2; o++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            model(1'(o), 4'(ai), 4'(bi), 1'(ci), es, ec);
            step(1'b0, 1'(o), 4'(ai), 4'(bi), 1'(ci), es, ec, "sweep");
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
